// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped peripheral block. It provides a UART byte
// handshake, free-running cycle and instruction counters, switch inputs,
// an LED register and an optional button event FIFO.
// Optional feature macro: MMIO_BTN_FIFO_EN. When it is defined, the button
// rising-edge detector and the event FIFO are built. When it is undefined,
// the FIFO status always reads "empty", the head reads 0 and buttons are ignored.
module mmio_ctrl #(
    parameter int NUM_BTN    = 3,
    parameter int NUM_LED    = 6,
    parameter int NUM_SW     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               we,
    input  logic               re,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               inst_retire,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic [NUM_SW-1:0]  switches,
    output logic [NUM_LED-1:0] leds
);

    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_RXD   = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_TXD   = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_CYC   = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_INS   = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] A_FSTAT = ADDR_W'(8'h20);
    localparam logic [ADDR_W-1:0] A_FHEAD = ADDR_W'(8'h24);
    localparam logic [ADDR_W-1:0] A_SW    = ADDR_W'(8'h28);
    localparam logic [ADDR_W-1:0] A_LED   = ADDR_W'(8'h30);

    // A combined store+load is a store only, so loads require ~we.
    logic        wr_en, rd_en;
    logic [31:0] rd_val;
    logic [31:0] cyc_cnt, ins_cnt;
    logic [31:0] fifo_stat, fifo_head;
    logic        clr_cnt;

    assign wr_en   = en & we;
    assign rd_en   = en & re & ~we;
    assign clr_cnt = wr_en & (addr == A_CLR);

    // Reading the rx data register consumes the byte. This is a one-cycle pulse.
    assign rx_ready = rd_en & (addr == A_RXD);

    // Load data mux. Unmapped and write-only offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (addr)
            A_STAT:  rd_val = {30'b0, rx_valid, ~tx_valid & tx_ready};
            A_RXD:   rd_val = 32'(rx_data);
            A_CYC:   rd_val = cyc_cnt;
            A_INS:   rd_val = ins_cnt;
            A_FSTAT: rd_val = fifo_stat;
            A_FHEAD: rd_val = fifo_head;
            A_SW:    rd_val = 32'(switches);
            default: rd_val = '0;
        endcase
    end

    // Registered load data. It holds its value between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rdata <= '0;
        else if (rd_en) rdata <= rd_val;
    end

    // Transmit holding register. A store while a byte is pending is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end else if (wr_en && addr == A_TXD && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= wdata[7:0];
        end
    end

    // Cycle and retire counters. Clearing wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (clr_cnt) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (inst_retire) ins_cnt <= ins_cnt + 32'd1;
        end
    end

    // LED output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          leds <= '0;
        else if (wr_en && addr == A_LED)   leds <= wdata[NUM_LED-1:0];
    end

`ifdef MMIO_BTN_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BTN-1:0] buttons_q, rise;
    logic [NUM_BTN-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wptr, rptr;
    logic               empty, full, push_req, push, pop, ovf, stat_rd;
    logic               unused_w;

    assign unused_w = ^wdata;

    // The pointers carry one extra wrap bit. When the index bits match,
    // equal wrap bits mean empty and different wrap bits mean full.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rise     = buttons & ~buttons_q;
    assign push_req = |rise;
    assign pop      = rd_en & (addr == A_FHEAD) & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push     = push_req & (~full | pop);
    assign stat_rd  = rd_en & (addr == A_FSTAT);

    assign fifo_stat = {30'b0, ovf, empty};
    assign fifo_head = empty ? '0 : 32'(mem[rptr[AW-1:0]]);

    // Event storage. It needs no reset because the pointers guard every entry.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= rise;
    end

    // Edge detector, pointers and sticky overflow (cleared by a status read)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buttons_q <= '0;
            wptr      <= '0;
            rptr      <= '0;
            ovf       <= 1'b0;
        end else begin
            buttons_q <= buttons;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push_req && full && !pop) ovf <= 1'b1;
            else if (stat_rd)             ovf <= 1'b0;
        end
    end
`else
    localparam int unused_depth = FIFO_DEPTH;
    logic unused_w;

    assign unused_w  = ^{wdata, buttons};
    assign fifo_stat = 32'h1;
    assign fifo_head = '0;
`endif

endmodule
